// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-boxes, round constants, GF(2^8) multiplies,
// FSM state encoding and FIPS byte-index helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEXP  = 2'd1,
        S_INIT  = 2'd2,
        S_ROUND = 2'd3
    } aes_state_e;

    // FIPS byte index of row r, column c (column-major layout)
    function automatic int bidx(input int r, input int c);
        return r + 4 * c;
    endfunction

    // Byte i of a 128-bit block; byte 0 sits in the top bits
    function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
        return v[127 - 8 * i -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Start/done handshake bundle shared with the encrypt core.
interface aes_decrypt_if;
    logic         start;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] out;
    logic         done;
    logic         busy;

    modport master (output start, data, key, input  out, done, busy);
    modport slave  (input  start, data, key, output out, done, busy);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);
    logic [7:0] t_b [16];
    logic [7:0] m_b [16];

    // Row r rotates right by r columns, then inverse S-box and round key
    always_comb begin
        for (int i = 0; i < 16; i++) t_b[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t_b[bidx(r, c)] = inv_sbox(get_byte(state_i, bidx(r, (c + 4 - r) % 4)))
                                  ^ get_byte(rk_i, bidx(r, c));
            end
        end
    end

    // InvMixColumns, one column at a time
    always_comb begin
        for (int i = 0; i < 16; i++) m_b[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            m_b[4*c+0] = gmul_0e(t_b[4*c]) ^ gmul_0b(t_b[4*c+1]) ^ gmul_0d(t_b[4*c+2]) ^ gmul_09(t_b[4*c+3]);
            m_b[4*c+1] = gmul_09(t_b[4*c]) ^ gmul_0e(t_b[4*c+1]) ^ gmul_0b(t_b[4*c+2]) ^ gmul_0d(t_b[4*c+3]);
            m_b[4*c+2] = gmul_0d(t_b[4*c]) ^ gmul_09(t_b[4*c+1]) ^ gmul_0e(t_b[4*c+2]) ^ gmul_0b(t_b[4*c+3]);
            m_b[4*c+3] = gmul_0b(t_b[4*c]) ^ gmul_0d(t_b[4*c+1]) ^ gmul_09(t_b[4*c+2]) ^ gmul_0e(t_b[4*c+3]);
        end
    end

    // Pack result, bypassing InvMixColumns on the final round
    always_comb begin
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            state_o[127 - 8 * i -: 8] = last_i ? t_b[i] : m_b[i];
        end
    end
endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock. The key is expanded
// forward to k10, then walked back one round key per inverse round.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; out holds last plaintext
// KEXP    | forward key schedule, rnd 1..10, rk ends at k10
// INIT    | initial AddRoundKey with k10
// ROUND   | inverse round rnd=9..0; rnd=0 writes out and pulses done
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    aes_decrypt_if.slave bus
);
    aes_state_e   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0, i1, i2, i3;
    logic [31:0]  sub_in, sub_out, rc_word;
    logic [127:0] rk_fwd, rk_inv, round_out;
    logic         last_round;

    assign {w0, w1, w2, w3} = rk_q;
    assign last_round       = (rnd_q == 4'd0);

    // Key steps in both directions; the four forward S-boxes are shared
    // because KEXP and ROUND never overlap.
    always_comb begin
        i3      = w3 ^ w2;
        i2      = w2 ^ w1;
        i1      = w1 ^ w0;
        sub_in  = (fsm_q == S_ROUND) ? rot_word(i3) : rot_word(w3);
        rc_word = {(fsm_q == S_ROUND) ? rcon(rnd_q + 4'd1) : rcon(rnd_q), 24'h0};
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        f0      = w0 ^ sub_out ^ rc_word;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        i0      = w0 ^ sub_out ^ rc_word;
        rk_fwd  = {f0, f1, f2, f3};
        rk_inv  = {i0, i1, i2, i3};
    end

    aes_inv_round u_inv_round (
        .state_i (st_q),
        .rk_i    (rk_inv),
        .last_i  (last_round),
        .state_o (round_out)
    );

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q  <= S_IDLE;
            rnd_q  <= 4'd0;
            st_q   <= '0;
            rk_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            st_q   <= st_d;
            rk_q   <= rk_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (bus.start) fsm_d = S_KEXP;
            S_KEXP:  if (rnd_q == 4'd10) fsm_d = S_INIT;
            S_INIT:  fsm_d = S_ROUND;
            S_ROUND: if (last_round) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Datapath updates and completion outputs per state
    always_comb begin
        st_d   = st_q;
        rk_d   = rk_q;
        rnd_d  = rnd_q;
        out_d  = out_q;
        done_d = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (bus.start) begin
                    st_d  = bus.data;
                    rk_d  = bus.key;
                    rnd_d = 4'd1;
                end
            end
            S_KEXP: begin
                rk_d  = rk_fwd;
                rnd_d = rnd_q + 4'd1;
            end
            S_INIT: begin
                st_d  = st_q ^ rk_q;
                rnd_d = 4'd9;
            end
            S_ROUND: begin
                if (last_round) begin
                    out_d  = round_out;
                    done_d = 1'b1;
                end else begin
                    st_d  = round_out;
                    rk_d  = rk_inv;
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = (fsm_q != S_IDLE);
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt using FIPS-197 known-answer vectors.
module tb_aes_decrypt;
    import aes_pkg::*;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] AB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] AB_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    aes_decrypt_if bus_if ();

    aes_decrypt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns at E0+1
    task automatic pulse_start(input logic [127:0] d, input logic [127:0] k);
        bus_if.start = 1'b1;
        bus_if.data  = d;
        bus_if.key   = k;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus_if.out !== 128'h0) begin
            n_miss++; $display("FAIL reset_out: got %h expected %h", bus_if.out, 128'h0);
        end
        n_vec++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_miss++; $display("FAIL reset_flags: got done=%b busy=%b expected 0 0", bus_if.done, bus_if.busy);
        end
        n_vec++;
        if (dut.rk_q !== 128'h0 || dut.st_q !== 128'h0 || dut.rnd_q !== 4'd0) begin
            n_miss++; $display("FAIL reset_regs: got rk=%h st=%h rnd=%0d expected zeros", dut.rk_q, dut.st_q, dut.rnd_q);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fips_c1();
        int first_done = 0;
        int pulses = 0;
        bit busy_ok = 1'b1;
        logic [127:0] got = '0;
        pulse_start(C1_CT, C1_KEY);
        if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (bus_if.done === 1'b1) begin
                pulses++;
                if (first_done == 0) begin first_done = i; got = bus_if.out; end
            end
            if (i < 21 && bus_if.busy !== 1'b1) busy_ok = 1'b0;
            if (i >= 21 && bus_if.busy !== 1'b0) busy_ok = 1'b0;
        end
        n_vec++;
        if (first_done != 21) begin
            n_miss++; $display("FAIL c1_latency: got done at E%0d expected E21", first_done);
        end
        n_vec++;
        if (got !== C1_PT) begin
            n_miss++; $display("FAIL c1_out: got %h expected %h", got, C1_PT);
        end
        n_vec++;
        if (pulses != 1) begin
            n_miss++; $display("FAIL c1_pulses: got %0d expected 1", pulses);
        end
        n_vec++;
        if (!busy_ok) begin
            n_miss++; $display("FAIL c1_busy: busy profile wrong, expected high E0..E20 and low from E21");
        end
        n_vec++;
        if (bus_if.out !== C1_PT) begin
            n_miss++; $display("FAIL c1_hold: got %h expected %h", bus_if.out, C1_PT);
        end
    endtask

    task automatic test_fips_app_b();
        pulse_start(AB_CT, AB_KEY);
        repeat (10) tick();
        n_vec++;
        if (dut.rk_q !== AB_K10) begin
            n_miss++; $display("FAIL appb_k10: got %h expected %h", dut.rk_q, AB_K10);
        end
        repeat (11) tick();
        n_vec++;
        if (bus_if.done !== 1'b1 || bus_if.out !== AB_PT) begin
            n_miss++; $display("FAIL appb_out: got done=%b out=%h expected 1 %h", bus_if.done, bus_if.out, AB_PT);
        end
        tick();
    endtask

    task automatic test_zero_vector();
        pulse_start(Z_CT, 128'h0);
        repeat (21) tick();
        n_vec++;
        if (bus_if.done !== 1'b1 || bus_if.out !== 128'h0) begin
            n_miss++; $display("FAIL zero_out: got done=%b out=%h expected 1 %h", bus_if.done, bus_if.out, 128'h0);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int first_done = 0;
        int pulses = 0;
        bit busy_ok = 1'b1;
        logic [127:0] got = '0;
        pulse_start(C1_CT, C1_KEY);
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                bus_if.start = 1'b1;
                bus_if.data  = AB_CT;
                bus_if.key   = AB_KEY;
            end else begin
                bus_if.start = 1'b0;
            end
            tick();
            if (bus_if.done === 1'b1) begin
                pulses++;
                if (first_done == 0) begin first_done = i; got = bus_if.out; end
            end
            if (i < 21 && bus_if.busy !== 1'b1) busy_ok = 1'b0;
        end
        n_vec++;
        if (first_done != 21 || got !== C1_PT) begin
            n_miss++; $display("FAIL busy_start_out: got E%0d %h expected E21 %h", first_done, got, C1_PT);
        end
        n_vec++;
        if (pulses != 1) begin
            n_miss++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses);
        end
        n_vec++;
        if (!busy_ok) begin
            n_miss++; $display("FAIL busy_start_busy: busy dropped before E21");
        end
    endtask

    task automatic test_back_to_back();
        int d1 = 0;
        int d2 = 0;
        int pulses = 0;
        bit stable = 1'b1;
        logic [127:0] o1 = '0;
        logic [127:0] o2 = '0;
        bus_if.start = 1'b1;
        bus_if.data  = C1_CT;
        bus_if.key   = C1_KEY;
        tick();
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 1) begin
                bus_if.data = AB_CT;
                bus_if.key  = AB_KEY;
            end
            if (bus_if.done === 1'b1) begin
                pulses++;
                if (d1 == 0) begin d1 = i; o1 = bus_if.out; end
                else if (d2 == 0) begin d2 = i; o2 = bus_if.out; bus_if.start = 1'b0; end
            end
            if (i > 21 && i < 43 && bus_if.out !== C1_PT) stable = 1'b0;
        end
        bus_if.start = 1'b0;
        n_vec++;
        if (d1 != 21 || o1 !== C1_PT) begin
            n_miss++; $display("FAIL b2b_first: got E%0d %h expected E21 %h", d1, o1, C1_PT);
        end
        n_vec++;
        if (d2 != 43 || o2 !== AB_PT) begin
            n_miss++; $display("FAIL b2b_second: got E%0d %h expected E43 %h", d2, o2, AB_PT);
        end
        n_vec++;
        if (!stable) begin
            n_miss++; $display("FAIL b2b_stable: out changed between completions");
        end
        n_vec++;
        if (pulses != 2) begin
            n_miss++; $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        pulse_start(C1_CT, C1_KEY);
        repeat (7) tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (bus_if.out !== 128'h0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_miss++; $display("FAIL midrst_state: got out=%h busy=%b done=%b expected 0 0 0", bus_if.out, bus_if.busy, bus_if.done);
        end
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_miss++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", pulses);
        end
        pulse_start(AB_CT, AB_KEY);
        repeat (21) tick();
        n_vec++;
        if (bus_if.done !== 1'b1 || bus_if.out !== AB_PT) begin
            n_miss++; $display("FAIL midrst_restart: got done=%b out=%h expected 1 %h", bus_if.done, bus_if.out, AB_PT);
        end
        tick();
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b0;
        bus_if.start = 1'b0;
        bus_if.data  = '0;
        bus_if.key   = '0;
        test_reset();
        test_fips_c1();
        test_fips_app_b();
        test_zero_vector();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
